// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: runs 32-bit add/sub and 16x16 multiply as two passes through a 16-bit combinational ALU
module alu_wide_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src,
  input  logic [31:0] req_dst,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_carry,
  output logic        resp_zero,
  output logic        resp_error,
  output logic [15:0] alu_source,
  output logic [15:0] alu_destination,
  output logic [3:0]  alu_op_code,
  output logic [15:0] alu_flags,
  input  logic [15:0] alu_result,
  input  logic        alu_carry
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [31:0] src, dst;
  logic is_sub, is_mul, active, high_word;
  logic [15:0] word_s, word_d;
  assign is_sub = op == 2'd1;
  assign is_mul = op == 2'd2;
  assign req_ready = state == IDLE;
  assign resp_zero = resp_valid && resp_result == 32'd0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      op          <= 2'd0;
      src         <= 32'd0;
      dst         <= 32'd0;
      resp_valid  <= 1'b0;
      resp_result <= 32'd0;
      resp_carry  <= 1'b0;
      resp_error  <= 1'b0;
    end else begin
      // resp_valid trails entry into DONE by one cycle and drops on the handshake
      resp_valid <= state == DONE && !(resp_valid && resp_ready);
      case (state)
        IDLE: if (req_valid) begin
          op         <= req_op;
          src        <= req_src;
          dst        <= req_dst;
          resp_error <= &req_op;
          state      <= &req_op ? DONE : LOW;
          if (&req_op) begin
            resp_result <= 32'd0;
            resp_carry  <= 1'b0;
          end
        end
        LOW: begin
          resp_result[15:0] <= alu_result;
          resp_carry        <= alu_carry;
          state             <= HIGH;
        end
        HIGH: begin
          resp_result[31:16] <= alu_result;
          resp_carry         <= !is_mul && alu_carry;
          state              <= DONE;
        end
        DONE: if (resp_valid && resp_ready) state <= IDLE;
      endcase
    end
  // MUL reuses the low words on the high pass to fetch the upper product half
  always_comb begin
    active          = state == LOW || state == HIGH;
    high_word       = state == HIGH && !is_mul;
    word_s          = high_word ? src[31:16] : src[15:0];
    word_d          = high_word ? dst[31:16] : dst[15:0];
    alu_op_code     = state == LOW ? (is_mul ? 4'hC : 4'hE) : state == HIGH ? (is_mul ? 4'hD : 4'hE) : 4'h0;
    alu_source      = active ? (is_sub ? ~word_s : word_s) : 16'h0;
    alu_destination = active ? word_d : 16'h0;
    alu_flags       = state == LOW ? {13'b0, is_sub, 2'b0} : high_word ? {13'b0, resp_carry, 2'b0} : 16'h0;
  end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: directed and random requests checked against plain 32-bit arithmetic
module tb_alu_wide_sequencer;
  logic clock = 0, reset_n = 0, req_valid = 0, resp_ready = 0;
  logic [1:0] req_op = 0;
  logic [31:0] req_src = 0, req_dst = 0;
  logic req_ready, resp_valid, resp_carry, resp_zero, resp_error, alu_carry;
  logic [31:0] resp_result;
  logic [15:0] alu_source, alu_destination, alu_flags, alu_result;
  logic [3:0] alu_op_code;
  logic [16:0] alu_sum;
  logic [31:0] alu_prod;
  int vectors = 0, miscompares = 0;
  always #5 clock = ~clock;
  alu_wide_sequencer dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_result(resp_result), .resp_carry(resp_carry),
    .resp_zero(resp_zero), .resp_error(resp_error), .alu_source(alu_source),
    .alu_destination(alu_destination), .alu_op_code(alu_op_code), .alu_flags(alu_flags),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );
  // 16-bit ALU: 0xE add with carry-in, 0xC/0xD low/high product, otherwise copy source
  assign alu_sum  = {1'b0, alu_source} + {1'b0, alu_destination} + {16'b0, alu_flags[2]};
  assign alu_prod = {16'b0, alu_source} * {16'b0, alu_destination};
  assign alu_result = alu_op_code == 4'hE ? alu_sum[15:0] : alu_op_code == 4'hC ? alu_prod[15:0] :
                      alu_op_code == 4'hD ? alu_prod[31:16] : alu_source;
  assign alu_carry = alu_op_code == 4'hE && alu_sum[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1;
    @(posedge clock); #1;
    resp_ready = 0;
    chk("resp_valid_drop", 64'(resp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] s, input logic [31:0] d, input bit complete);
    logic [32:0] wide;
    logic [31:0] er;
    logic ec, lo_c;
    logic [3:0] lo_op, hi_op;
    logic [15:0] lo_fl, hi_fl;
    int n;
    er = 0; ec = 0; wide = 0;
    case (op)
      2'd0: begin wide = {1'b0, s} + {1'b0, d}; er = wide[31:0]; ec = wide[32]; end
      2'd1: begin er = d - s; ec = d >= s; end
      2'd2: er = {16'b0, s[15:0]} * {16'b0, d[15:0]};
      default: ;
    endcase
    lo_c = op == 2'd0 ? (32'(s[15:0]) + 32'(d[15:0])) > 32'hFFFF : d[15:0] >= s[15:0];
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1; req_op = op; req_src = s; req_dst = d;
    @(posedge clock); #1;
    req_valid = 0;
    lo_op = alu_op_code; lo_fl = alu_flags;
    hi_op = 0; hi_fl = 0; n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) begin hi_op = alu_op_code; hi_fl = alu_flags; end
    end
    chk("latency", 64'(n), op == 2'd3 ? 64'd1 : 64'd3);
    chk("result", 64'(resp_result), 64'(er));
    chk("carry", 64'(resp_carry), 64'(ec));
    chk("zero", 64'(resp_zero), 64'(er == 0));
    chk("error", 64'(resp_error), 64'(op == 2'd3));
    chk("low_op", 64'(lo_op), op == 2'd3 ? 64'h0 : op == 2'd2 ? 64'hC : 64'hE);
    chk("high_op", 64'(hi_op), op == 2'd3 ? 64'h0 : op == 2'd2 ? 64'hD : 64'hE);
    chk("low_flags", 64'(lo_fl), op == 2'd1 ? 64'h4 : 64'h0);
    chk("high_flags", 64'(hi_fl), op < 2'd2 ? 64'({lo_c, 2'b0}) : 64'h0);
    if (complete) finish_resp();
  endtask

  initial begin
    logic [31:0] held;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'({resp_result, resp_carry, resp_zero, resp_error}), 64'd0);
    chk("rst_alu", 64'({alu_source, alu_destination, alu_op_code, alu_flags}), 64'd0);
    #10 reset_n = 1;
    request(2'd0, 32'h0000_0001, 32'h0000_FFFF, 1);
    request(2'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1);
    request(2'd1, 32'h0000_0001, 32'h0001_0000, 1);
    request(2'd1, 32'h0000_0001, 32'h0000_0000, 1);
    request(2'd2, 32'hABCD_FFFF, 32'h1234_FFFF, 1);
    request(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    request(2'd1, 32'h8000_0000, 32'h8000_0000, 1);
    for (int i = 0; i < 24; i++)
      request(2'($urandom_range(0, 3)), $urandom, $urandom, 1);
    request(2'd0, 32'h1234_5678, 32'h1111_1111, 0);
    held = resp_result;
    req_valid = 1; req_op = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("hold_result", 64'(resp_result), 64'(held));
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 0;
    finish_resp();
    @(posedge clock); #1;
    chk("no_queued_valid", 64'(resp_valid), 64'd0);
    chk("no_queued_alu", 64'(alu_op_code), 64'd0);
    req_valid = 1; req_op = 2'd0; req_src = 32'h0001_0001; req_dst = 32'h0002_0002;
    @(posedge clock); #1;
    req_valid = 0;
    @(posedge clock); #1;
    chk("in_high", 64'(alu_op_code), 64'hE);
    reset_n = 0;
    #1;
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_alu", 64'({alu_source, alu_destination, alu_op_code, alu_flags}), 64'd0);
    chk("abort_result", 64'({resp_result, resp_carry, resp_zero, resp_error}), 64'd0);
    @(negedge clock);
    reset_n = 1;
    request(2'd2, 32'h0000_0003, 32'h0000_0005, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
